// File: rtl/decode_step.sv
// Decode stage: captures a fetched RV32I word and its PC, then splits the word into
// register indices, a sign-extended immediate, an op class and an illegal flag.
// The decoded bundle is held until execute accepts it.
module decode_step #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned OPCLASS_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 fetch_finished_i,
   input  logic [XLEN-1:0]      instruction_i,
   input  logic [XLEN-1:0]      pc_i,
   input  logic                 flush_i,
   input  logic                 execute_ready_i,
   output logic                 decode_working_o,
   output logic                 decode_valid_o,
   output logic [XLEN-1:0]      pc_o,
   output logic [4:0]           rs1_o,
   output logic [4:0]           rs2_o,
   output logic [4:0]           rd_o,
   output logic [2:0]           funct3_o,
   output logic [6:0]           funct7_o,
   output logic [XLEN-1:0]      imm_o,
   output logic [OPCLASS_W-1:0] op_class_o,
   output logic                 reg_write_o,
   output logic                 illegal_o,
   output logic [31:0]          decoded_count_o
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [OPCLASS_W-1:0] CLS_LUI     = OPCLASS_W'(0);
   localparam logic [OPCLASS_W-1:0] CLS_AUIPC   = OPCLASS_W'(1);
   localparam logic [OPCLASS_W-1:0] CLS_JAL     = OPCLASS_W'(2);
   localparam logic [OPCLASS_W-1:0] CLS_JALR    = OPCLASS_W'(3);
   localparam logic [OPCLASS_W-1:0] CLS_BRANCH  = OPCLASS_W'(4);
   localparam logic [OPCLASS_W-1:0] CLS_LOAD    = OPCLASS_W'(5);
   localparam logic [OPCLASS_W-1:0] CLS_STORE   = OPCLASS_W'(6);
   localparam logic [OPCLASS_W-1:0] CLS_OP_IMM  = OPCLASS_W'(7);
   localparam logic [OPCLASS_W-1:0] CLS_OP      = OPCLASS_W'(8);
   localparam logic [OPCLASS_W-1:0] CLS_FENCE   = OPCLASS_W'(9);
   localparam logic [OPCLASS_W-1:0] CLS_SYSTEM  = OPCLASS_W'(10);
   localparam logic [OPCLASS_W-1:0] CLS_ILLEGAL = OPCLASS_W'(15);

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic {S_IDLE, S_FULL} state_t;

   state_t state;

   logic [6:0]           opc;
   logic [2:0]           f3;
   logic [6:0]           f7;
   logic [4:0]           rd_f;
   logic [XLEN-1:0]      imm_i_f, imm_s_f, imm_b_f, imm_u_f, imm_j_f;
   logic                 in_ready;
   logic                 accept;
   logic                 dec_illegal;
   logic                 dec_writes;
   logic                 dec_reg_write;
   logic [OPCLASS_W-1:0] dec_class;
   logic [XLEN-1:0]      dec_imm;

   assign opc  = instruction_i[6:0];
   assign f3   = instruction_i[14:12];
   assign f7   = instruction_i[31:25];
   assign rd_f = instruction_i[11:7];

   // Immediate formats, all sign-extended from bit 31 except U
   assign imm_i_f = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:20]};
   assign imm_s_f = {{(XLEN-12){instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
   assign imm_b_f = {{(XLEN-12){instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                     instruction_i[11:8], 1'b0};
   assign imm_u_f = {instruction_i[31:12], 12'b0};
   assign imm_j_f = {{(XLEN-20){instruction_i[31]}}, instruction_i[19:12], instruction_i[20],
                     instruction_i[30:21], 1'b0};

   // Stall fetch whenever the held bundle cannot be replaced this cycle
   assign in_ready         = (state == S_IDLE) | execute_ready_i;
   assign decode_working_o = ~in_ready;
   assign accept           = fetch_finished_i & in_ready & ~flush_i;
   assign decode_valid_o   = (state == S_FULL);

   // Classify the incoming word and pick its immediate; illegal words collapse to class 15
   always_comb begin
      dec_illegal = 1'b0;
      dec_writes  = 1'b0;
      dec_class   = CLS_ILLEGAL;
      dec_imm     = '0;
      case (opc)
         OPC_LUI: begin
            dec_class  = CLS_LUI;
            dec_imm    = imm_u_f;
            dec_writes = 1'b1;
         end
         OPC_AUIPC: begin
            dec_class  = CLS_AUIPC;
            dec_imm    = imm_u_f;
            dec_writes = 1'b1;
         end
         OPC_JAL: begin
            dec_class  = CLS_JAL;
            dec_imm    = imm_j_f;
            dec_writes = 1'b1;
         end
         OPC_JALR: begin
            dec_class   = CLS_JALR;
            dec_imm     = imm_i_f;
            dec_writes  = 1'b1;
            dec_illegal = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            dec_class   = CLS_BRANCH;
            dec_imm     = imm_b_f;
            dec_illegal = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            dec_class   = CLS_LOAD;
            dec_imm     = imm_i_f;
            dec_writes  = 1'b1;
            dec_illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            dec_class   = CLS_STORE;
            dec_imm     = imm_s_f;
            dec_illegal = (f3 >= 3'b011);
         end
         OPC_OP_IMM: begin
            dec_class  = CLS_OP_IMM;
            dec_imm    = imm_i_f;
            dec_writes = 1'b1;
            if (f3 == 3'b001)
               dec_illegal = (f7 != F7_ZERO);
            else if (f3 == 3'b101)
               dec_illegal = (f7 != F7_ZERO) && (f7 != F7_ALT);
         end
         OPC_OP: begin
            dec_class  = CLS_OP;
            dec_writes = 1'b1;
            if (f7 == F7_ALT)
               dec_illegal = (f3 != 3'b000) && (f3 != 3'b101);
            else
               dec_illegal = (f7 != F7_ZERO);
         end
         OPC_FENCE: begin
            dec_class = CLS_FENCE;
         end
         OPC_SYSTEM: begin
            dec_class = CLS_SYSTEM;
            dec_imm   = imm_i_f;
         end
         default: dec_illegal = 1'b1;
      endcase
      if ((instruction_i[1:0] != 2'b11) || (instruction_i == '0) || (&instruction_i))
         dec_illegal = 1'b1;
      if (dec_illegal) begin
         dec_class  = CLS_ILLEGAL;
         dec_imm    = '0;
         dec_writes = 1'b0;
      end
   end

   assign dec_reg_write = dec_writes & (rd_f != 5'd0);

   // Hold/replace the bundle and count hand-offs; flush wins over everything but reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= S_IDLE;
         pc_o            <= '0;
         rs1_o           <= '0;
         rs2_o           <= '0;
         rd_o            <= '0;
         funct3_o        <= '0;
         funct7_o        <= '0;
         imm_o           <= '0;
         op_class_o      <= '0;
         reg_write_o     <= 1'b0;
         illegal_o       <= 1'b0;
         decoded_count_o <= '0;
      end else begin
         if (decode_valid_o && execute_ready_i && !flush_i)
            decoded_count_o <= decoded_count_o + 32'd1;
         if (flush_i) begin
            state <= S_IDLE;
         end else if (accept) begin
            state       <= S_FULL;
            pc_o        <= pc_i;
            rs1_o       <= instruction_i[19:15];
            rs2_o       <= instruction_i[24:20];
            rd_o        <= rd_f;
            funct3_o    <= f3;
            funct7_o    <= f7;
            imm_o       <= dec_imm;
            op_class_o  <= dec_class;
            reg_write_o <= dec_reg_write;
            illegal_o   <= dec_illegal;
         end else if (execute_ready_i) begin
            state <= S_IDLE;
         end
      end
   end

endmodule
